vectoring_cordic: RTL and testbench

- Iterative vectoring-mode CORDIC: the inverse direction of the rotational CORDIC pipeline. Takes a Cartesian vector (x, y) and returns its magnitude and angle (atan2), driving y to zero over successive micro-rotations.
- Shares the rotational block's fixed-point format: 2^14 = 1.0, angles in radians × 2^14, same arctangent table.
- Multi-cycle FSM with a start/busy/done handshake, not a pipeline. Sits beside the rotational pipeline to convert rotated outputs back to polar form.

---
 rtl/vectoring_cordic.sv | 186 ++++++++++++++++++
 tb/tb_vectoring_cordic.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vectoring_cordic.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian vector (x, y) into
// magnitude and atan2 angle. Fixed point 2^14 = 1.0, angles in radians x 2^14.
// Optional build macro VECTORING_CORDIC_ROUND_EN selects round-half-up on the
// final gain-compensation multiply; otherwise the result truncates.
module vectoring_cordic #(
  parameter int unsigned ITERS    = 16,
  parameter int unsigned K_SCALED = 9949
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        busy,
  output logic        data_out_vec,
  output logic [15:0] magnitude,
  output logic [16:0] theta
);

  typedef enum logic [1:0] {StIdle, StIter, StScale} state_e;

  localparam logic signed [16:0] HalfPi = 17'sd25736;
  localparam logic [4:0]         LastIter = 5'(ITERS - 1);

  state_e             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic signed [17:0] xr_q, xr_d;
  logic signed [17:0] yr_q, yr_d;
  logic signed [16:0] z_q, z_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               dvec_q, dvec_d;
  logic [15:0]        mag_q, mag_d;
  logic [16:0]        theta_q, theta_d;

  // Sign-extended inputs so that negating -32768 stays exact.
  logic signed [17:0] x_ext, y_ext;
  logic signed [17:0] x_shift, y_shift;
  logic signed [16:0] angle;
  logic [35:0]        prod;

  // Arctangent table: atan(2^-i) in radians x 2^14.
  function automatic logic signed [16:0] atan_lut(input logic [4:0] idx);
    logic signed [16:0] val;
    unique case (idx)
      5'd0:    val = 17'sd12868;
      5'd1:    val = 17'sd7596;
      5'd2:    val = 17'sd4014;
      5'd3:    val = 17'sd2037;
      5'd4:    val = 17'sd1023;
      5'd5:    val = 17'sd512;
      5'd6:    val = 17'sd256;
      5'd7:    val = 17'sd128;
      5'd8:    val = 17'sd64;
      5'd9:    val = 17'sd32;
      5'd10:   val = 17'sd16;
      5'd11:   val = 17'sd8;
      5'd12:   val = 17'sd4;
      5'd13:   val = 17'sd2;
      5'd14:   val = 17'sd1;
      default: val = 17'sd0;
    endcase
    return val;
  endfunction

  assign x_ext   = {{2{x[15]}}, x};
  assign y_ext   = {{2{y[15]}}, y};
  assign x_shift = xr_q >>> iter_q;
  assign y_shift = yr_q >>> iter_q;
  assign angle   = atan_lut(iter_q);

  // Gain compensation; xr is non-negative once converged so an unsigned
  // product of the low bits is exact.
`ifdef VECTORING_CORDIC_ROUND_EN
  assign prod = {18'd0, xr_q} * 36'(K_SCALED) + 36'd8192;
`else
  assign prod = {18'd0, xr_q} * 36'(K_SCALED);
`endif

  // State register and datapath flops; async active-low reset clears all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      iter_q  <= 5'd0;
      xr_q    <= 18'sd0;
      yr_q    <= 18'sd0;
      z_q     <= 17'sd0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      dvec_q  <= 1'b0;
      mag_q   <= 16'd0;
      theta_q <= 17'd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      dvec_q  <= dvec_d;
      mag_q   <= mag_d;
      theta_q <= theta_d;
    end
  end

  // Next-state logic: latch with quadrant pre-rotation, iterate, then scale.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    z_d     = z_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    dvec_d  = 1'b0;
    mag_d   = mag_q;
    theta_d = theta_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Fold the left half-plane into the right so iterations converge.
          if (!x[15]) begin
            xr_d = x_ext;
            yr_d = y_ext;
            z_d  = 17'sd0;
          end else if (!y[15]) begin
            xr_d = y_ext;
            yr_d = -x_ext;
            z_d  = HalfPi;
          end else begin
            xr_d = -y_ext;
            yr_d = x_ext;
            z_d  = -HalfPi;
          end
          zero_d  = (x == 16'd0) && (y == 16'd0);
          iter_d  = 5'd0;
          busy_d  = 1'b1;
          state_d = StIter;
        end
      end

      StIter: begin
        if (!yr_q[17]) begin
          xr_d = xr_q + y_shift;
          yr_d = yr_q - x_shift;
          z_d  = z_q + angle;
        end else begin
          xr_d = xr_q - y_shift;
          yr_d = yr_q + x_shift;
          z_d  = z_q - angle;
        end
        if (iter_q == LastIter) begin
          state_d = StScale;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end

      StScale: begin
        if (zero_q) begin
          mag_d   = 16'd0;
          theta_d = 17'd0;
        end else begin
          mag_d   = prod[29:14];
          theta_d = z_q;
        end
        dvec_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy         = busy_q;
  assign data_out_vec = dvec_q;
  assign magnitude    = mag_q;
  assign theta        = theta_q;

endmodule

// File: tb/tb_vectoring_cordic.sv
// Self-checking bench for vectoring_cordic: a cycle model predicts busy and
// the result pulse, and a scoreboard queue holds ideal magnitude/angle values
// computed from real arithmetic at the moment each start is accepted.
module tb_vectoring_cordic;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic               busy;
  logic               data_out_vec;
  logic [15:0]        magnitude;
  logic [16:0]        theta;

  typedef struct {
    int mag;
    int th;
    bit exact;
  } exp_t;

  exp_t sb[$];
  int   rem = 0;
  int   n_asserts = 0;
  int   n_fail = 0;

  vectoring_cordic dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .x            (x),
    .y            (y),
    .busy         (busy),
    .data_out_vec (data_out_vec),
    .magnitude    (magnitude),
    .theta        (theta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
    int d;
    bit ok;
    d  = obs - expv;
    if (d < 0) d = -d;
    ok = (d <= tol);
    n_asserts++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
    end
  endtask

  // Ideal polar result of the inputs currently driven.
  function automatic exp_t ideal(input int xi, input int yi);
    exp_t e;
    real  xf, yf;
    xf = $itor(xi);
    yf = $itor(yi);
    e.exact = (xi == 0) && (yi == 0);
    if (e.exact) begin
      e.mag = 0;
      e.th  = 0;
    end else begin
      e.mag = int'($sqrt(xf * xf + yf * yf));
      e.th  = int'($atan2(yf, xf) * 16384.0);
    end
    return e;
  endfunction

  // One clock: advance the model at the edge, then check 1 ns later.
  task automatic tick();
    bit   accept;
    bit   dv_exp;
    exp_t e;
    accept = (rem == 0) && (start === 1'b1) && (reset === 1'b1);
    dv_exp = (rem == 1);
    if (accept) sb.push_back(ideal(int'(x), int'(y)));
    @(posedge clk);
    if (accept) rem = 17;
    else if (rem > 0) rem--;
    #1;
    chk("busy", int'(busy), (rem > 0) ? 1 : 0);
    chk("data_out_vec", int'(data_out_vec), dv_exp ? 1 : 0);
    if (dv_exp && data_out_vec === 1'b1) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        if (e.exact) begin
          chk("magnitude_zero", int'(magnitude), 0);
          chk("theta_zero", int'($signed(theta)), 0);
        end else begin
          chk_tol("magnitude", int'(magnitude), e.mag, 3);
          chk_tol("theta", int'($signed(theta)), e.th, 4);
        end
      end
    end
  endtask

  task automatic run_one(input int xi, input int yi);
    x     = 16'(xi);
    y     = 16'(yi);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_dvec", int'(data_out_vec), 0);
    chk("reset_mag", int'(magnitude), 0);
    chk("reset_theta", int'(theta), 0);
    reset = 1'b1;
    tick();

    // Directed vectors covering all quadrant pre-rotation branches.
    run_one(16384, 0);
    run_one(0, 16384);
    run_one(11585, 11585);
    run_one(-16384, 0);
    run_one(-32768, -32768);
    run_one(16384, -16384);
    run_one(-12000, 9000);
    run_one(0, 0);
    run_one(0, -16384);

    // Start held high with fresh inputs every cycle; only idle starts count.
    start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      int xv, yv;
      xv = int'($urandom_range(4000, 20000));
      if ($urandom_range(0, 1) == 1) xv = -xv;
      yv = int'($urandom_range(0, 40000)) - 20000;
      x  = 16'(xv);
      y  = 16'(yv);
      tick();
    end
    start = 1'b0;
    repeat (20) tick();
    chk("sb_drained_hold", sb.size(), 0);

    // Abort a conversion mid-iteration with reset.
    x     = 16'sd20000;
    y     = 16'sd3000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_dvec", int'(data_out_vec), 0);
    chk("abort_mag", int'(magnitude), 0);
    chk("abort_theta", int'(theta), 0);
    sb.delete();
    rem = 0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    run_one(16384, -16384);
    chk("sb_drained_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
